// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache in front of a 64-bit burst RAM.
// Each line holds 8 x 32-bit words, moved as 4 beats of 64 bits.
// Beat k carries word 2k in its low half and word 2k+1 in its high half.
// Optional macro CACHE_INFO_EN adds a simulation-only trace of every miss.
// The synthesized logic is the same whether or not the macro is defined.
module cache #(
    parameter int LINE_IX_BITWIDTH    = 1,
    parameter int RAM_DEPTH_BITWIDTH  = 10,
    parameter int RAM_ADDRESSING_MODE = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [31:0]                   address,
    input  logic [31:0]                   data_in,
    input  logic [3:0]                    write_enable,
    output logic [31:0]                   data_out,
    output logic                          data_out_ready,
    output logic                          busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                   br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [63:0]                   br_rd_data,
    input  logic                          br_rd_data_valid
);

    localparam int NUM_LINES = 1 << LINE_IX_BITWIDTH;
    localparam int TAG_W     = 32 - 5 - LINE_IX_BITWIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_RD_CMD,
        S_RD_WAIT
    } state_e;

    // Controller state.
    state_e                      state_q, state_d;
    logic [2:0]                  beat_q, beat_d;
    logic [LINE_IX_BITWIDTH-1:0] miss_index_q, miss_index_d;
    logic [TAG_W-1:0]            miss_tag_q, miss_tag_d;
    logic [NUM_LINES-1:0]        valid_q, valid_d;
    logic [NUM_LINES-1:0]        dirty_q, dirty_d;

    // Line storage.
    logic [TAG_W-1:0]            tag_mem  [NUM_LINES];
    logic [31:0]                 data_mem [NUM_LINES][8];

    // Request decode.
    logic [2:0]                  req_word;
    logic [LINE_IX_BITWIDTH-1:0] req_index;
    logic [TAG_W-1:0]            req_tag;
    logic                        unused_addr_bits;

    assign req_word         = address[4:2];
    assign req_index        = address[5 +: LINE_IX_BITWIDTH];
    assign req_tag          = address[31 -: TAG_W];
    assign unused_addr_bits = ^address[1:0];

    // Lookup and control strobes.
    logic        is_idle;
    logic        hit;
    logic        miss;
    logic        hit_write;
    logic        fill_beat;
    logic        fill_last;
    logic [31:0] stored_word;
    logic [31:0] merged_word;
    logic [31:0] evict_byte_addr;
    logic [31:0] refill_byte_addr;

    assign is_idle     = (state_q == S_IDLE);
    assign hit         = enable && valid_q[req_index] && (tag_mem[req_index] == req_tag);
    assign miss        = is_idle && enable && !hit;
    assign hit_write   = is_idle && hit && (write_enable != 4'b0000);
    assign fill_beat   = (state_q == S_RD_WAIT) && br_rd_data_valid;
    assign fill_last   = fill_beat && (beat_q[1:0] == 2'd3);
    assign stored_word = data_mem[req_index][req_word];

    // Line base addresses for write-back (old tag) and refill (latched tag).
    assign evict_byte_addr  = {tag_mem[miss_index_q], miss_index_q, 5'b00000};
    assign refill_byte_addr = {miss_tag_q, miss_index_q, 5'b00000};

    // Merge the enabled byte lanes of data_in into the stored word for a write hit.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        merged_word = stored_word;
        for (int b = 0; b < 4; b++) begin
            if (write_enable[b]) begin
                merged_word[8*b +: 8] = data_in[8*b +: 8];
            end
        end
    end

    // Next-state logic: miss detection, write-back sequencing, refill tracking.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        miss_index_d = miss_index_q;
        miss_tag_d   = miss_tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;

        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    miss_index_d = req_index;
                    miss_tag_d   = req_tag;
                    beat_d       = 3'd0;
                    // Only a valid dirty victim has to go back to RAM first.
                    if (valid_q[req_index] && dirty_q[req_index]) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_RD_CMD;
                    end
                    // The line is being replaced, so it stops matching right away.
                    valid_d[req_index] = 1'b0;
                    dirty_d[req_index] = 1'b0;
                end else if (hit_write) begin
                    dirty_d[req_index] = 1'b1;
                end
            end

            S_WB: begin
                // Beats 0..3 go out on counts 0..3; count 4 is the gap cycle.
                if (beat_q == 3'd4) begin
                    beat_d  = 3'd0;
                    state_d = S_RD_CMD;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end

            S_RD_CMD: begin
                beat_d  = 3'd0;
                state_d = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                // No timeout: the RAM is trusted to deliver all four beats.
                if (fill_beat) begin
                    beat_d = beat_q + 3'd1;
                    if (fill_last) begin
                        beat_d                = 3'd0;
                        valid_d[miss_index_q] = 1'b1;
                        dirty_d[miss_index_q] = 1'b0;
                        state_d               = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Burst-RAM command and write-beat outputs, decoded from the current state.
    always_comb begin
        br_cmd_en  = 1'b0;
        br_cmd     = 1'b0;
        br_addr    = '0;
        br_wr_data = '0;

        unique case (state_q)
            S_WB: begin
                br_cmd  = 1'b1;
                br_addr = RAM_DEPTH_BITWIDTH'(evict_byte_addr >> RAM_ADDRESSING_MODE);
                if (beat_q == 3'd0) begin
                    br_cmd_en = 1'b1;
                end
                if (beat_q != 3'd4) begin
                    br_wr_data = {data_mem[miss_index_q][{beat_q[1:0], 1'b1}],
                                  data_mem[miss_index_q][{beat_q[1:0], 1'b0}]};
                end
            end

            S_RD_CMD: begin
                br_cmd_en = 1'b1;
                br_cmd    = 1'b0;
                br_addr   = RAM_DEPTH_BITWIDTH'(refill_byte_addr >> RAM_ADDRESSING_MODE);
            end

            default: begin
            end
        endcase
    end

    assign br_data_mask = 8'h00;

    // Caller-facing handshake.
    // rst_n gates both strobes so they read 0 for the whole time reset is held.
    assign data_out       = stored_word;
    assign data_out_ready = rst_n && is_idle && hit;
    assign busy           = rst_n && (!is_idle || (enable && !hit));

    // Controller state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= 3'd0;
            miss_index_q <= '0;
            miss_tag_q   <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            miss_index_q <= miss_index_d;
            miss_tag_q   <= miss_tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    // Line storage writes: refill beats and write-hit byte merges.
    // NOTE: data and tag arrays have no reset; the valid bits alone say whether contents count.
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[miss_index_q][{beat_q[1:0], 1'b0}] <= br_rd_data[31:0];
            data_mem[miss_index_q][{beat_q[1:0], 1'b1}] <= br_rd_data[63:32];
            if (fill_last) begin
                tag_mem[miss_index_q] <= miss_tag_q;
            end
        end else if (hit_write) begin
            data_mem[req_index][req_word] <= merged_word;
        end
    end

`ifdef CACHE_INFO_EN
    // Simulation-only trace of each miss as it is detected.
    always @(posedge clk) begin
        if (rst_n && miss) begin
            $display("cache: miss addr=%08h index=%0d evicted_tag=%0h dirty=%0b",
                     address, req_index, tag_mem[req_index],
                     valid_q[req_index] & dirty_q[req_index]);
        end
    end
`endif

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: a small burst-RAM responder plus hand-computed expectations.
// Unwritten RAM beat i holds {0xA0000000 + 2i + 1, 0xA0000000 + 2i}.
// As a result, the word at byte address a reads as 0xA0000000 + a/4.
module tb_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  write_enable = 4'h0;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [9:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;

    cache dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .address          (address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- burst-RAM responder ----------------
    logic        rsp_valid;
    logic        noise_valid = 1'b0;
    logic [63:0] rsp_data;
    assign br_rd_data_valid = rsp_valid | noise_valid;
    assign br_rd_data       = rsp_data;

    int          rd_cmds = 0;
    int          wr_cmds = 0;
    int          wb_beats = 0;
    int          cmd_pulses = 0;
    int          rd_step = 0;
    int          rd_sent = 0;
    int          rd_cmd_cyc = 0;
    int          wr_cmd_cyc = 0;
    logic [2:0]  wb_idx = 3'd0;
    logic [9:0]  rd_base = 10'd0;
    logic [9:0]  wb_base = 10'd0;
    logic        wb_done = 1'b0;
    logic [63:0] wb_log [4];

    function automatic logic [63:0] ram_beat(input logic [9:0] a);
        logic [9:0] off;
        off = a - wb_base;
        if (wb_done && a >= wb_base && off < 10'd4) return wb_log[off[1:0]];
        return {32'hA000_0000 + 32'(2 * a + 1), 32'hA000_0000 + 32'(2 * a)};
    endfunction

    // Observe commands on the falling edge; return read beats with a one-cycle gap after beat 1.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rd_step   <= 0;
            rd_sent   <= 0;
            wb_idx    <= 3'd0;
        end else begin
            rsp_valid <= 1'b0;
            if (br_cmd_en) cmd_pulses <= cmd_pulses + 1;
            if (br_cmd_en && br_cmd) begin
                wr_cmds    <= wr_cmds + 1;
                wr_cmd_cyc <= cyc;
                wb_base    <= br_addr;
                wb_log[0]  <= br_wr_data;
                wb_beats   <= 1;
                wb_done    <= 1'b0;
                wb_idx     <= 3'd1;
            end else if (wb_idx != 3'd0) begin
                wb_log[wb_idx[1:0]] <= br_wr_data;
                wb_beats <= wb_beats + 1;
                if (wb_idx == 3'd3) begin
                    wb_idx  <= 3'd0;
                    wb_done <= 1'b1;
                end else begin
                    wb_idx <= wb_idx + 3'd1;
                end
            end
            if (br_cmd_en && !br_cmd) begin
                rd_cmds    <= rd_cmds + 1;
                rd_cmd_cyc <= cyc;
                rd_base    <= br_addr;
                rd_step    <= 1;
                rd_sent    <= 0;
            end else if (rd_step != 0) begin
                if (rd_step inside {2, 3, 5, 6}) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= ram_beat(rd_base + 10'(rd_sent));
                    rd_sent   <= rd_sent + 1;
                end
                rd_step <= (rd_step == 6) ? 0 : rd_step + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Apply a request just after a rising edge, then move to the following falling edge.
    task automatic drive(input logic en, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(posedge clk);
        #1;
        enable       = en;
        address      = a;
        write_enable = we;
        data_in      = d;
        @(negedge clk);
    endtask

    // Wait a bounded number of falling edges for data_out_ready.
    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!data_out_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(data_out_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses_before;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(data_out_ready), 64'd0);
        check("rst_cmd_en", 64'(br_cmd_en), 64'd0);
        check("rst_cmd", 64'(br_cmd), 64'd0);
        check("rst_addr", 64'(br_addr), 64'd0);
        check("rst_wr_data", br_wr_data, 64'd0);
        check("rst_mask", 64'(br_data_mask), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold read miss of 0x4: one read command at 0, word 1 from beat 0 high half.
        drive(1'b1, 32'h0000_0004, 4'h0, 32'h0);
        check("miss4_busy", 64'(busy), 64'd1);
        check("miss4_not_ready", 64'(data_out_ready), 64'd0);
        wait_ready("miss4", 40);
        check("miss4_data", 64'(data_out), 64'hA000_0001);
        check("miss4_busy_done", 64'(busy), 64'd0);
        check("miss4_rd_cmds", 64'(rd_cmds), 64'd1);
        check("miss4_rd_addr", 64'(rd_base), 64'h000);
        check("miss4_beats", 64'(rd_sent), 64'd4);

        // Read hit on the same line, same cycle.
        drive(1'b1, 32'h0000_0008, 4'h0, 32'h0);
        check("hit8_ready", 64'(data_out_ready), 64'd1);
        check("hit8_busy", 64'(busy), 64'd0);
        check("hit8_data", 64'(data_out), 64'hA000_0002);

        // Write hit on byte lane 2: old word this cycle, merged word next cycle.
        drive(1'b1, 32'h0000_0008, 4'b0100, 32'hDEAD_BEEF);
        check("wr8_ready", 64'(data_out_ready), 64'd1);
        check("wr8_old_data", 64'(data_out), 64'hA000_0002);
        drive(1'b1, 32'h0000_0008, 4'h0, 32'h0);
        check("wr8_new_data", 64'(data_out), 64'hA0AD_0002);
        check("wr8_no_cmd", 64'(rd_cmds + wr_cmds), 64'd1);

        // Conflict miss on dirty line: write-back at 0, gap cycle, then read at 8.
        drive(1'b1, 32'h0000_0040, 4'h0, 32'h0);
        check("miss40_busy", 64'(busy), 64'd1);
        wait_ready("miss40", 60);
        check("miss40_data", 64'(data_out), 64'hA000_0010);
        check("wb0_cmds", 64'(wr_cmds), 64'd1);
        check("wb0_addr", 64'(wb_base), 64'h000);
        check("wb0_beats", 64'(wb_beats), 64'd4);
        check("wb0_beat0", wb_log[0], 64'hA000_0001_A000_0000);
        check("wb0_beat1", wb_log[1], 64'hA000_0003_A0AD_0002);
        check("miss40_rd_cmds", 64'(rd_cmds), 64'd2);
        check("miss40_rd_addr", 64'(rd_base), 64'h008);
        check("wb0_to_rd_gap", 64'(rd_cmd_cyc - wr_cmd_cyc), 64'd5);

        // Clean miss back to 0x8 returns the written-back byte merge.
        drive(1'b1, 32'h0000_0008, 4'h0, 32'h0);
        check("re8_busy", 64'(busy), 64'd1);
        wait_ready("re8", 40);
        check("re8_data", 64'(data_out), 64'hA0AD_0002);
        check("re8_no_wb", 64'(wr_cmds), 64'd1);
        check("re8_rd_addr", 64'(rd_base), 64'h000);

        // Reset while beat 2 of the refill for 0x24 is on the bus.
        drive(1'b1, 32'h0000_0024, 4'h0, 32'h0);
        n = 0;
        while (!(rd_cmds == 4 && rd_sent == 3) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_mid_beat2", 64'(rd_sent), 64'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_cmd_en", 64'(br_cmd_en), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_ready", 64'(data_out_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("re24_busy", 64'(busy), 64'd1);
        wait_ready("re24", 40);
        check("re24_data", 64'(data_out), 64'hA000_0009);
        check("re24_rd_cmds", 64'(rd_cmds), 64'd5);
        check("re24_rd_addr", 64'(rd_base), 64'h004);

        // Idle with spurious read-valid pulses: nothing moves.
        drive(1'b0, 32'h0000_0024, 4'h0, 32'h0);
        #1 pulses_before = cmd_pulses;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 noise_valid = ~noise_valid;
            @(negedge clk);
            check("idle_ready", 64'(data_out_ready), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_cmd_en", 64'(br_cmd_en), 64'd0);
        end
        @(posedge clk);
        #1 noise_valid = 1'b0;
        @(negedge clk);
        #1 check("idle_no_cmds", 64'(cmd_pulses - pulses_before), 64'd0);
        drive(1'b1, 32'h0000_0024, 4'h0, 32'h0);
        check("idle_rehit_ready", 64'(data_out_ready), 64'd1);
        check("idle_rehit_data", 64'(data_out), 64'hA000_0009);

        // Write miss allocates the line, then the held write lands in the first idle cycle.
        drive(1'b1, 32'h0000_0064, 4'hF, 32'h1234_5678);
        check("wm64_busy", 64'(busy), 64'd1);
        wait_ready("wm64", 40);
        check("wm64_fill_data", 64'(data_out), 64'hA000_0019);
        check("wm64_rd_addr", 64'(rd_base), 64'h00C);
        check("wm64_no_wb", 64'(wr_cmds), 64'd1);
        drive(1'b1, 32'h0000_0064, 4'h0, 32'h0);
        check("wm64_new_data", 64'(data_out), 64'h1234_5678);

        // Evict that dirty line from index 1: write-back at 0xC, then refill at 4.
        drive(1'b1, 32'h0000_0024, 4'h0, 32'h0);
        check("ev24_busy", 64'(busy), 64'd1);
        wait_ready("ev24", 60);
        check("ev24_data", 64'(data_out), 64'hA000_0009);
        check("wbc_cmds", 64'(wr_cmds), 64'd2);
        check("wbc_addr", 64'(wb_base), 64'h00C);
        check("wbc_beat0", wb_log[0], 64'h1234_5678_A000_0018);
        check("ev24_rd_addr", 64'(rd_base), 64'h004);
        check("wbc_to_rd_gap", 64'(rd_cmd_cyc - wr_cmd_cyc), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache.md
CACHE -- requirements
Module: cache

Interface
REQ-001 Parameter LINE_IX_BITWIDTH, default 1, log2 of number of cache lines.
REQ-002 Parameter RAM_DEPTH_BITWIDTH, default 10, width of burst-RAM address.
REQ-003 Parameter RAM_ADDRESSING_MODE, default 3, right-shift from byte address to burst-RAM address (3 = 64-bit words).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  request valid.
REQ-007 address  in  32  byte address, bits[1:0] ignored (word access).
REQ-008 data_in  in  32  write data, byte lanes per write_enable.
REQ-009 write_enable  in  4  byte-lane write enables; 0 = read.
REQ-010 data_out  out  32  addressed word.
REQ-011 data_out_ready  out  1  data_out valid for current address.
REQ-012 busy  out  1  line transfer in progress; caller holds inputs.
REQ-013 br_cmd  out  1  0 read, 1 write.
REQ-014 br_cmd_en  out  1  command/address valid, one-cycle pulse.
REQ-015 br_addr  out  RAM_DEPTH_BITWIDTH  burst-RAM address.
REQ-016 br_wr_data  out  64  write beat.
REQ-017 br_data_mask  out  8  constant 0 (all bytes written).
REQ-018 br_rd_data  in  64  read beat.
REQ-019 br_rd_data_valid  in  1  br_rd_data valid this cycle.

Function
REQ-020 Direct-mapped, write-back, write-allocate; line = 8 words = 4 beats of 64 bits; beat k holds words 2k (low half) and 2k+1 (high half).
REQ-021 Address split: word = address[4:2], index = address[4+LINE_IX_BITWIDTH:5], tag = remaining upper bits; per line: valid, dirty, tag.
REQ-022 Hit = enable & valid[index] & tag match; on hit in IDLE: data_out = stored word combinationally, data_out_ready=1, busy=0 same cycle.
REQ-023 Write hit: enabled byte lanes of data_in written at next rising edge, dirty set; data_out shows old word that cycle, new word next cycle.
REQ-024 enable=0: data_out_ready=0, busy=0, no state change, no RAM command.
REQ-025 Miss: busy=1, data_out_ready=0 from the miss cycle until refill completes; tag/index latched at miss.
REQ-026 States: IDLE -> (miss & dirty) WB -> RD_CMD -> RD_WAIT -> IDLE; (miss & clean) IDLE -> RD_CMD.
REQ-027 WB: cycle 0 br_cmd_en=1, br_cmd=1, br_addr=({old tag,index,5'b0})>>RAM_ADDRESSING_MODE, br_wr_data=beat 0; cycles 1-3 beats 1-3 with br_cmd_en=0; then one idle cycle.
REQ-028 RD_CMD: one cycle br_cmd_en=1, br_cmd=0, br_addr=({new tag,index,5'b0})>>RAM_ADDRESSING_MODE, truncated to RAM_DEPTH_BITWIDTH.
REQ-029 RD_WAIT: each br_rd_data_valid cycle stores next beat (0..3); after beat 3: valid=1, dirty=0, tag updated, state IDLE.
REQ-030 First IDLE cycle after refill re-evaluates inputs; the held request then hits (writes applied then).
REQ-031 Address changed while busy: refill completes for latched line; new address evaluated in IDLE.
REQ-032 br_rd_data_valid outside RD_WAIT ignored; no timeout in RD_WAIT.

Reset
REQ-033 rst_n low: state IDLE, all valid and dirty cleared, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, busy=0, data_out_ready=0; in-flight transfer abandoned, data not written back.
REQ-034 Data/tag arrays need no reset.

Configuration
REQ-035 Macro CACHE_INFO_EN defined: simulation prints on every miss (address, index, evicted tag, dirty flag); undefined: no prints; synthesized logic identical either way.

Verification
REQ-036 After reset, read 0x00000004 -> busy=1, one read command br_addr=0x000, 4 beats; word 1 = high half of beat 0; then data_out_ready=1, busy=0.
REQ-037 Write 0xDEADBEEF, write_enable=4'b0100 to 0x00000008 after fill -> next read returns byte 2 replaced (0x00AD0000 lane), dirty set, no RAM command.
REQ-038 With default params, access 0x00000040 (same index, different tag) after dirty line -> write command br_addr=0x000 with 4 beats, then read command br_addr=0x008.
REQ-039 Reset asserted during RD_WAIT beat 2 -> br_cmd_en=0, busy=0; re-read same address misses and refetches.
REQ-040 enable=0 for 10 cycles with br_rd_data_valid toggling -> no command, no state change, data_out_ready=0.
